// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller for the 8-bit execute ALU.
// Accepts one 16-bit instruction, reads both operands from an internal
// 8x8 register file and drives them to the ALU. One clock later it takes
// the ALU's registered result and commits it to the register file or to
// the CARRY/FLAG state. Each instruction runs IDLE -> ISSUE -> WB.
// Optional feature: define ALU_SEQ_TRAP_EN to add the ERR port. Illegal
// encodings are then sequenced with their writeback suppressed.
module alu_sequencer #(
   parameter logic [7:0] RF_RESET_VAL = 8'h00
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] INST,
   input  logic        INST_VALID,
   output logic        INST_READY,
   output logic        DONE,
`ifdef ALU_SEQ_TRAP_EN
   output logic        ERR,
`endif
   output logic [7:0]  ALU_A,
   output logic [7:0]  ALU_B,
   output logic [3:0]  ALU_CAL,
   output logic [1:0]  ALU_MODE,
   output logic        ALU_C_IN,
   output logic        ALU_F_IN,
   input  logic [7:0]  ALU_OUT,
   input  logic        ALU_C_OUT,
   input  logic        ALU_F_OUT,
   input  logic [2:0]  DBG_ADDR,
   output logic [7:0]  DBG_DATA,
   output logic        CARRY,
   output logic        FLAG
);

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

   state_t            state;
   logic [DATA_W-1:0] rf [0:7];
   logic [2:0]        rd_q;
   logic              wb_en;

`ifdef ALU_SEQ_TRAP_EN
   logic              illegal_q;

   // Encodings the ALU does not implement, plus a set reserved bit.
   function automatic logic is_illegal(input logic [15:0] inst);
      return ((inst[15:14] == 2'b00) && (inst[13:10] >= 4'hC)) ||
             ((inst[15:14] == 2'b01) && (inst[13:10] >= 4'h6)) ||
             inst[0];
   endfunction

   assign wb_en = !illegal_q;
`else
   // The reserved bit is ignored when trapping is not built in.
   logic unused_inst0;
   assign unused_inst0 = INST[0];
   assign wb_en        = 1'b1;
`endif

   // Debug port is a plain combinational read of the register file.
   assign DBG_DATA = rf[DBG_ADDR];

   // Sequencer: issue on accept, hold while the ALU samples, commit in WB.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         INST_READY <= 1'b1;
         DONE       <= 1'b0;
         ALU_A      <= '0;
         ALU_B      <= '0;
         ALU_CAL    <= '0;
         ALU_MODE   <= 2'b10;
         ALU_C_IN   <= 1'b0;
         ALU_F_IN   <= 1'b0;
         CARRY      <= 1'b0;
         FLAG       <= 1'b0;
         rd_q       <= '0;
         for (int i = 0; i < 8; i++) rf[i] <= RF_RESET_VAL;
`ifdef ALU_SEQ_TRAP_EN
         ERR        <= 1'b0;
         illegal_q  <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (INST_VALID) begin
                  // Operands are captured here, so a later write to RA/RB
                  // by this same instruction cannot disturb them.
                  ALU_MODE   <= INST[15:14];
                  ALU_CAL    <= INST[13:10];
                  rd_q       <= INST[9:7];
                  ALU_A      <= rf[INST[6:4]];
                  ALU_B      <= rf[INST[3:1]];
                  ALU_C_IN   <= CARRY;
                  ALU_F_IN   <= FLAG;
`ifdef ALU_SEQ_TRAP_EN
                  illegal_q  <= is_illegal(INST);
`endif
                  INST_READY <= 1'b0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WB;
            end
            WB: begin
               if (wb_en) begin
                  case (ALU_MODE)
                     2'b00: begin
                        rf[rd_q] <= ALU_OUT;
                        CARRY    <= ALU_C_OUT;
                        FLAG     <= 1'b0;
                     end
                     2'b01: begin
                        FLAG <= ALU_F_OUT;
                     end
                     default: begin
                        rf[rd_q] <= ALU_OUT;
                     end
                  endcase
               end
`ifdef ALU_SEQ_TRAP_EN
               if (illegal_q) ERR <= 1'b1;
`endif
               DONE       <= 1'b1;
               INST_READY <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               INST_READY <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a behavioural ALU
// stub. The stub registers its result one clock after sampling, which
// matches the real execute ALU. It can also be told to return an immediate
// value, so that move instructions can seed registers.
module tb_alu_sequencer;

   logic        CLK;
   logic        RST_N;
   logic [15:0] INST;
   logic        INST_VALID;
   logic        INST_READY;
   logic        DONE;
   logic        ERR;
   logic [7:0]  ALU_A, ALU_B;
   logic [3:0]  ALU_CAL;
   logic [1:0]  ALU_MODE;
   logic        ALU_C_IN, ALU_F_IN;
   logic [7:0]  ALU_OUT;
   logic        ALU_C_OUT, ALU_F_OUT;
   logic [2:0]  DBG_ADDR;
   logic [7:0]  DBG_DATA;
   logic        CARRY, FLAG;

   logic        stub_imm_en;
   logic [7:0]  stub_imm;
   logic [8:0]  stub_r;
   logic        stub_f;

   int total = 0;
   int bad   = 0;

   alu_sequencer #(.RF_RESET_VAL(8'h00)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .INST       (INST),
      .INST_VALID (INST_VALID),
      .INST_READY (INST_READY),
      .DONE       (DONE),
`ifdef ALU_SEQ_TRAP_EN
      .ERR        (ERR),
`endif
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_CAL    (ALU_CAL),
      .ALU_MODE   (ALU_MODE),
      .ALU_C_IN   (ALU_C_IN),
      .ALU_F_IN   (ALU_F_IN),
      .ALU_OUT    (ALU_OUT),
      .ALU_C_OUT  (ALU_C_OUT),
      .ALU_F_OUT  (ALU_F_OUT),
      .DBG_ADDR   (DBG_ADDR),
      .DBG_DATA   (DBG_DATA),
      .CARRY      (CARRY),
      .FLAG       (FLAG)
   );

`ifndef ALU_SEQ_TRAP_EN
   assign ERR = 1'b0;
`endif

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ALU stub: combinational function of the presented inputs.
   always_comb begin
      stub_r = '0;
      stub_f = 1'b0;
      case (ALU_MODE)
         2'b00: begin
            case (ALU_CAL)
               4'h0: stub_r = {1'b0, ALU_A} + {1'b0, ALU_B};
               4'h1: stub_r = {1'b0, ALU_A} - {1'b0, ALU_B};
               4'h2: stub_r = {1'b0, ALU_A & ALU_B};
               4'h3: stub_r = {1'b0, ALU_A | ALU_B};
               4'h4: stub_r = {1'b0, ALU_A ^ ALU_B};
               4'h9: stub_r = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_C_IN};
               4'hA: stub_r = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'h00, ALU_C_IN};
               default: stub_r = '0;
            endcase
         end
         2'b01: begin
            case (ALU_CAL)
               4'h0: stub_f = (ALU_A == ALU_B);
               4'h1: stub_f = (ALU_A != ALU_B);
               4'h2: stub_f = (ALU_A <  ALU_B);
               4'h3: stub_f = (ALU_A >  ALU_B);
               4'h4: stub_f = (ALU_A <= ALU_B);
               4'h5: stub_f = (ALU_A >= ALU_B);
               default: stub_f = 1'b0;
            endcase
         end
         default: stub_r = {1'b0, ALU_A};
      endcase
      if (stub_imm_en) stub_r = {1'b0, stub_imm};
   end

   // ALU stub output register.
   always @(posedge CLK) begin
      ALU_OUT   <= stub_r[7:0];
      ALU_C_OUT <= stub_r[8];
      ALU_F_OUT <= stub_f;
   end

   function automatic logic [15:0] enc(input logic [1:0] m, input logic [3:0] c,
                                       input logic [2:0] rd, input logic [2:0] ra,
                                       input logic [2:0] rb);
      return {m, c, rd, ra, rb, 1'b0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
      DBG_ADDR = a;
      #1;
      v = DBG_DATA;
   endtask

   // Issue one instruction. Returns the number of falling edges from the
   // accept edge to the one that first sees DONE (-1 if none), plus the
   // ALU inputs seen during ISSUE. It returns inside the DONE cycle.
   task automatic run_inst(input logic [15:0] ins, output int lat,
                           output logic [7:0] a, output logic [7:0] b,
                           output logic cin);
      lat = -1;
      a   = '0;
      b   = '0;
      cin = 1'b0;
      @(negedge CLK);
      chk("ready_before_accept", 32'(INST_READY), 1);
      INST       = ins;
      INST_VALID = 1'b1;
      @(posedge CLK);
      #1 INST_VALID = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            a   = ALU_A;
            b   = ALU_B;
            cin = ALU_C_IN;
         end
         if (DONE) begin
            lat = k;
            break;
         end
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] inst;
      logic        imm_en;
      logic [7:0]  imm;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      logic        exp_cin;
      logic [2:0]  chk_reg;
      logic [7:0]  exp_val;
      logic        exp_c;
      logic        exp_f;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          lat;
      logic [7:0]  a, b, v;
      logic        cin;
      logic [15:0] b2b [4];
      logic [7:0]  snap [8];
      int          idx, dones, lows, accepts;
      logic        acc;

      vecs[0]  = '{"mov_r1_imm", enc(2'b10, 4'h0, 3'd1, 3'd0, 3'd0), 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 3'd1, 8'hF0, 1'b0, 1'b0};
      vecs[1]  = '{"mov_r2_imm", enc(2'b10, 4'h0, 3'd2, 3'd0, 3'd0), 1'b1, 8'h20, 8'h00, 8'h00, 1'b0, 3'd2, 8'h20, 1'b0, 1'b0};
      vecs[2]  = '{"add_r3",     enc(2'b00, 4'h0, 3'd3, 3'd1, 3'd2), 1'b0, 8'h00, 8'hF0, 8'h20, 1'b0, 3'd3, 8'h10, 1'b1, 1'b0};
      vecs[3]  = '{"adc_r4",     enc(2'b00, 4'h9, 3'd4, 3'd0, 3'd0), 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 3'd4, 8'h01, 1'b0, 1'b0};
      vecs[4]  = '{"cmp_gt",     enc(2'b01, 4'h3, 3'd5, 3'd1, 3'd2), 1'b0, 8'h00, 8'hF0, 8'h20, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1};
      vecs[5]  = '{"sub_r5",     enc(2'b00, 4'h1, 3'd5, 3'd2, 3'd1), 1'b0, 8'h00, 8'h20, 8'hF0, 1'b0, 3'd5, 8'h30, 1'b1, 1'b0};
      vecs[6]  = '{"sbc_r6",     enc(2'b00, 4'hA, 3'd6, 3'd1, 3'd2), 1'b0, 8'h00, 8'hF0, 8'h20, 1'b1, 3'd6, 8'hCF, 1'b0, 1'b0};
      vecs[7]  = '{"and_r7",     enc(2'b00, 4'h2, 3'd7, 3'd1, 3'd2), 1'b0, 8'h00, 8'hF0, 8'h20, 1'b0, 3'd7, 8'h20, 1'b0, 1'b0};
      vecs[8]  = '{"mov_r0_r3",  enc(2'b11, 4'h0, 3'd0, 3'd3, 3'd0), 1'b0, 8'h00, 8'h10, 8'h00, 1'b0, 3'd0, 8'h10, 1'b0, 1'b0};
      vecs[9]  = '{"cmp_eq",     enc(2'b01, 4'h0, 3'd2, 3'd3, 3'd0), 1'b0, 8'h00, 8'h10, 8'h10, 1'b0, 3'd2, 8'h20, 1'b0, 1'b1};
      vecs[10] = '{"mov_r4_r1",  enc(2'b10, 4'h0, 3'd4, 3'd1, 3'd0), 1'b0, 8'h00, 8'hF0, 8'h10, 1'b0, 3'd4, 8'hF0, 1'b0, 1'b1};
      vecs[11] = '{"add_r4_self", enc(2'b00, 4'h0, 3'd4, 3'd4, 3'd4), 1'b0, 8'h00, 8'hF0, 8'hF0, 1'b0, 3'd4, 8'hE0, 1'b1, 1'b0};

      snap = '{8'h00, 8'hF0, 8'h20, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00};

      RST_N       = 1'b0;
      INST        = '0;
      INST_VALID  = 1'b0;
      DBG_ADDR    = '0;
      stub_imm_en = 1'b0;
      stub_imm    = '0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ready", 32'(INST_READY), 1);
      chk("rst_done",  32'(DONE), 0);
      chk("rst_mode",  32'(ALU_MODE), 2);
      chk("rst_a",     32'(ALU_A), 0);
      chk("rst_b",     32'(ALU_B), 0);
      chk("rst_cal",   32'(ALU_CAL), 0);
      chk("rst_cin",   32'(ALU_C_IN), 0);
      chk("rst_fin",   32'(ALU_F_IN), 0);
      chk("rst_carry", 32'(CARRY), 0);
      chk("rst_flag",  32'(FLAG), 0);
      chk("rst_err",   32'(ERR), 0);
      rd_reg(3'd3, v);
      chk("rst_rf3", 32'(v), 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Table-driven instruction stream
      for (int i = 0; i < 12; i++) begin
         stub_imm_en = vecs[i].imm_en;
         stub_imm    = vecs[i].imm;
         run_inst(vecs[i].inst, lat, a, b, cin);
         stub_imm_en = 1'b0;
         chk({vecs[i].name, "_latency"}, 32'(lat), 3);
         chk({vecs[i].name, "_alu_a"}, 32'(a), 32'(vecs[i].exp_a));
         chk({vecs[i].name, "_alu_b"}, 32'(b), 32'(vecs[i].exp_b));
         chk({vecs[i].name, "_alu_cin"}, 32'(cin), 32'(vecs[i].exp_cin));
         rd_reg(vecs[i].chk_reg, v);
         chk({vecs[i].name, "_rf"}, 32'(v), 32'(vecs[i].exp_val));
         chk({vecs[i].name, "_carry"}, 32'(CARRY), 32'(vecs[i].exp_c));
         chk({vecs[i].name, "_flag"}, 32'(FLAG), 32'(vecs[i].exp_f));
         if (i == 4) begin
            for (int r = 0; r < 8; r++) begin
               rd_reg(3'(r), v);
               chk($sformatf("cmp_rf_unchanged_r%0d", r), 32'(v), 32'(snap[r]));
            end
         end
      end

      // Back-to-back: INST_VALID held high across four instructions
      b2b[0] = enc(2'b00, 4'h2, 3'd5, 3'd1, 3'd1);  // R5 = F0 & F0 = F0, C=0
      b2b[1] = enc(2'b00, 4'h0, 3'd5, 3'd5, 3'd5);  // R5 = F0 + F0 = E0, C=1
      b2b[2] = enc(2'b00, 4'h9, 3'd5, 3'd5, 3'd3);  // R5 = E0 + 10 + 1 = F1, C=0
      b2b[3] = enc(2'b00, 4'h0, 3'd5, 3'd5, 3'd2);  // R5 = F1 + 20 = 11, C=1
      idx = 0; dones = 0; lows = 0; accepts = 0;
      @(posedge CLK);
      #1;
      INST       = b2b[0];
      INST_VALID = 1'b1;
      for (int cyc = 0; cyc < 40 && dones < 4; cyc++) begin
         @(negedge CLK);
         if (DONE) dones++;
         if (!INST_READY) lows++;
         acc = INST_READY && INST_VALID;
         @(posedge CLK);
         #1;
         if (acc) begin
            accepts++;
            idx++;
            if (idx < 4) INST = b2b[idx];
            else INST_VALID = 1'b0;
         end
      end
      INST_VALID = 1'b0;
      chk("b2b_accepts", 32'(accepts), 4);
      chk("b2b_dones", 32'(dones), 4);
      chk("b2b_ready_low_cycles", 32'(lows), 8);
      rd_reg(3'd5, v);
      chk("b2b_r5", 32'(v), 32'h11);
      chk("b2b_carry", 32'(CARRY), 1);

      // Reset asserted while SUB R5=R1-R2 is in ISSUE
      @(negedge CLK);
      INST       = enc(2'b00, 4'h1, 3'd5, 3'd1, 3'd2);
      INST_VALID = 1'b1;
      @(posedge CLK);
      #1 INST_VALID = 1'b0;
      @(negedge CLK);
      chk("issue_ready_low", 32'(INST_READY), 0);
      RST_N = 1'b0;
      #1;
      chk("midrst_ready", 32'(INST_READY), 1);
      chk("midrst_mode", 32'(ALU_MODE), 2);
      chk("midrst_a", 32'(ALU_A), 0);
      chk("midrst_carry", 32'(CARRY), 0);
      rd_reg(3'd1, v);
      chk("midrst_r1", 32'(v), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      chk("midrst_no_done", 32'(dones), 0);
      chk("midrst_ready_after", 32'(INST_READY), 1);
      rd_reg(3'd5, v);
      chk("midrst_r5", 32'(v), 0);

      // Illegal encoding: MODE 00, CAL 1111 writing a seeded R6
      stub_imm_en = 1'b1;
      stub_imm    = 8'h55;
      run_inst(enc(2'b10, 4'h0, 3'd6, 3'd0, 3'd0), lat, a, b, cin);
      stub_imm_en = 1'b0;
      rd_reg(3'd6, v);
      chk("seed_r6", 32'(v), 32'h55);
      chk("pre_ill_err", 32'(ERR), 0);
      run_inst(enc(2'b00, 4'hF, 3'd6, 3'd6, 3'd6), lat, a, b, cin);
      chk("ill_latency", 32'(lat), 3);
      rd_reg(3'd6, v);
`ifdef ALU_SEQ_TRAP_EN
      chk("ill_r6_kept", 32'(v), 32'h55);
      chk("ill_err", 32'(ERR), 1);
`else
      chk("ill_r6_written", 32'(v), 32'h00);
      chk("ill_err_absent", 32'(ERR), 0);
`endif
      run_inst(enc(2'b10, 4'h0, 3'd7, 3'd6, 3'd0), lat, a, b, cin);
      chk("post_ill_latency", 32'(lat), 3);
`ifdef ALU_SEQ_TRAP_EN
      chk("err_sticky", 32'(ERR), 1);
      rd_reg(3'd7, v);
      chk("post_ill_r7", 32'(v), 32'h55);
`else
      rd_reg(3'd7, v);
      chk("post_ill_r7", 32'(v), 32'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
